// File: rtl/ibex_irq_ctrl_pkg.sv
// Shared constants and types for the interrupt front-end: CSR bit positions,
// cause codes and the priority-encoder result type.
package ibex_irq_ctrl_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned CAUSE_W = 6;
  localparam int unsigned CODE_W  = 5;

  localparam int unsigned IRQ_FAST_MAX = 15;

  // mip/mie bit positions
  localparam int unsigned CSR_MSIX     = 3;
  localparam int unsigned CSR_MTIX     = 7;
  localparam int unsigned CSR_MEIX     = 11;
  localparam int unsigned CSR_MFIX_LOW = 16;

  // Interrupt cause codes (the interrupt flag is prepended on output)
  localparam logic [CODE_W-1:0] EXC_CAUSE_IRQ_SOFTWARE_M = 5'd3;
  localparam logic [CODE_W-1:0] EXC_CAUSE_IRQ_TIMER_M    = 5'd7;
  localparam logic [CODE_W-1:0] EXC_CAUSE_IRQ_EXTERNAL_M = 5'd11;
  localparam logic [CODE_W-1:0] EXC_CAUSE_IRQ_FAST_BASE  = 5'd16;
  localparam logic [CODE_W-1:0] EXC_CAUSE_IRQ_NM         = 5'd31;

  typedef struct packed {
    logic              valid;
    logic [CODE_W-1:0] code;
  } irq_sel_t;

  // Writable/readable mip/mie bits for a given fast-IRQ count
  function automatic logic [XLEN-1:0] irq_csr_mask(input int unsigned num_fast);
    logic [XLEN-1:0] mask;
    mask           = '0;
    mask[CSR_MSIX] = 1'b1;
    mask[CSR_MTIX] = 1'b1;
    mask[CSR_MEIX] = 1'b1;
    for (int unsigned i = 0; i < num_fast; i++) begin
      mask[5'(CSR_MFIX_LOW + i)] = 1'b1;
    end
    return mask;
  endfunction

endpackage

// File: rtl/ibex_irq_prio_enc.sv
// Fixed-priority selector: NMI > MEI > MSI > MTI > fast[0] > ... > fast[N-1].
module ibex_irq_prio_enc
  import ibex_irq_ctrl_pkg::*;
#(
  parameter int unsigned NumFastIrqs = 15
) (
  input  logic                   nmi,
  input  logic                   external,
  input  logic                   software,
  input  logic                   timer,
  input  logic [NumFastIrqs-1:0] fast,
  output irq_sel_t               sel
);

  // Lowest-priority candidates are applied first so higher ones overwrite them
  always_comb begin
    sel = '0;
    for (int i = int'(NumFastIrqs) - 1; i >= 0; i--) begin
      if (fast[i]) begin
        sel.valid = 1'b1;
        sel.code  = EXC_CAUSE_IRQ_FAST_BASE + 5'(i);
      end
    end
    if (timer) begin
      sel.valid = 1'b1;
      sel.code  = EXC_CAUSE_IRQ_TIMER_M;
    end
    if (software) begin
      sel.valid = 1'b1;
      sel.code  = EXC_CAUSE_IRQ_SOFTWARE_M;
    end
    if (external) begin
      sel.valid = 1'b1;
      sel.code  = EXC_CAUSE_IRQ_EXTERNAL_M;
    end
    if (nmi) begin
      sel.valid = 1'b1;
      sel.code  = EXC_CAUSE_IRQ_NM;
    end
  end

endmodule

// File: rtl/ibex_irq_ctrl.sv
// Interrupt front-end: latches edge sources, owns mie, and presents a registered
// prioritised request/cause to the controller with ack-based clearing.
module ibex_irq_ctrl
  import ibex_irq_ctrl_pkg::*;
#(
  parameter int unsigned            NumFastIrqs = 15,
  parameter logic [NumFastIrqs-1:0] IrqEdgeMask = '0
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   irq_software_i,
  input  logic                   irq_timer_i,
  input  logic                   irq_external_i,
  input  logic [NumFastIrqs-1:0] irq_fast_i,
  input  logic                   irq_nm_i,
  input  logic                   mstatus_mie_i,
  input  logic                   debug_mode_i,
  input  logic                   nmi_mode_i,
  input  logic                   csr_mie_we_i,
  input  logic                   csr_mip_we_i,
  input  logic [XLEN-1:0]        csr_wdata_i,
  output logic [XLEN-1:0]        csr_mie_o,
  output logic [XLEN-1:0]        csr_mip_o,
  output logic                   irq_req_o,
  output logic [CAUSE_W-1:0]     irq_cause_o,
  output logic                   irq_pending_o,
  input  logic                   irq_ack_i
);

  localparam int unsigned     N       = NumFastIrqs;
  localparam logic [XLEN-1:0] CsrMask = irq_csr_mask(N);

  if (N < 1 || N > IRQ_FAST_MAX) begin : g_bad_num_fast
    $error("NumFastIrqs must be within 1..%0d", IRQ_FAST_MAX);
  end

  logic [XLEN-1:0]    mie_q;
  logic [N-1:0]       fast_pend_q, fast_pend_d, fast_prev_q;
  logic [N-1:0]       fast_set, fast_clr, fast_ack, fast_mip, fast_elig;
  logic               nmi_pend_q, nmi_pend_d, nmi_prev_q;
  logic               nmi_set, nmi_ack, nmi_elig;
  logic               ack_valid;
  logic [XLEN-1:0]    mip, en;
  logic               irq_req_q, irq_req_d;
  logic               irq_pending_q, irq_pending_d;
  logic [CAUSE_W-1:0] irq_cause_q, irq_cause_d;
  irq_sel_t           sel;

  // An ack only counts while a request is actually being presented
  assign ack_valid = irq_ack_i & irq_req_q;

  // Edge detection and pending update; a fresh edge beats any same-cycle clear
  always_comb begin
    fast_set = IrqEdgeMask & irq_fast_i & ~fast_prev_q;
    fast_ack = '0;
    for (int unsigned i = 0; i < N; i++) begin
      fast_ack[i] = ack_valid &
                    (irq_cause_q[CODE_W-1:0] == EXC_CAUSE_IRQ_FAST_BASE + 5'(i));
    end
    fast_clr    = fast_ack | ({N{csr_mip_we_i}} & ~csr_wdata_i[CSR_MFIX_LOW +: N]);
    fast_pend_d = IrqEdgeMask & (fast_set | (fast_pend_q & ~fast_clr));

    nmi_set    = irq_nm_i & ~nmi_prev_q;
    nmi_ack    = ack_valid & (irq_cause_q[CODE_W-1:0] == EXC_CAUSE_IRQ_NM);
    nmi_pend_d = nmi_set | (nmi_pend_q & ~nmi_ack);
  end

  // mip view: level bits follow the pins, edge bits show the latched pending
  always_comb begin
    fast_mip = (IrqEdgeMask & fast_pend_q) | (~IrqEdgeMask & irq_fast_i);
    mip                      = '0;
    mip[CSR_MSIX]            = irq_software_i;
    mip[CSR_MTIX]            = irq_timer_i;
    mip[CSR_MEIX]            = irq_external_i;
    mip[CSR_MFIX_LOW +: N]   = fast_mip;
  end

  always_comb begin
    en        = mip & mie_q;
    fast_elig = en[CSR_MFIX_LOW +: N] & {N{mstatus_mie_i}};
    nmi_elig  = nmi_pend_q & ~nmi_mode_i;
  end

  ibex_irq_prio_enc #(
    .NumFastIrqs (N)
  ) u_prio_enc (
    .nmi      (nmi_elig),
    .external (en[CSR_MEIX] & mstatus_mie_i),
    .software (en[CSR_MSIX] & mstatus_mie_i),
    .timer    (en[CSR_MTIX] & mstatus_mie_i),
    .fast     (fast_elig),
    .sel      (sel)
  );

  // Request is dropped for the cycle after an ack so a stale request cannot be retaken
  always_comb begin
    irq_req_d     = ~debug_mode_i & sel.valid & ~ack_valid;
    irq_cause_d   = irq_req_d ? {1'b1, sel.code} : irq_cause_q;
    irq_pending_d = |en;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mie_q         <= '0;
      fast_pend_q   <= '0;
      fast_prev_q   <= '0;
      nmi_pend_q    <= 1'b0;
      nmi_prev_q    <= 1'b0;
      irq_req_q     <= 1'b0;
      irq_cause_q   <= '0;
      irq_pending_q <= 1'b0;
    end else begin
      if (csr_mie_we_i) begin
        mie_q <= csr_wdata_i & CsrMask;
      end
      fast_pend_q   <= fast_pend_d;
      fast_prev_q   <= irq_fast_i;
      nmi_pend_q    <= nmi_pend_d;
      nmi_prev_q    <= irq_nm_i;
      irq_req_q     <= irq_req_d;
      irq_cause_q   <= irq_cause_d;
      irq_pending_q <= irq_pending_d;
    end
  end

  assign csr_mie_o     = mie_q;
  assign csr_mip_o     = mip;
  assign irq_req_o     = irq_req_q;
  assign irq_cause_o   = irq_cause_q;
  assign irq_pending_o = irq_pending_q;

  ack_without_req_a: assert property (
    @(posedge clk_i) disable iff (!rst_ni) irq_ack_i |-> irq_req_q
  );

endmodule
